// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default widths for the CDB arbiter and its source FIFOs.
package cdb_arbiter_pkg;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSU = 1'b1
  } cdb_src_e;

  localparam int unsigned CDB_FIFO_DEPTH = 4;
  localparam int unsigned CDB_ROB_ID_W   = 5;
  localparam int unsigned CDB_DATA_W     = 32;

  // ALU entry: {rob_id, result, jump_flag, target_pc}
  function automatic int unsigned alu_entry_w(input int unsigned rob_id_w, input int unsigned data_w);
    return rob_id_w + 2 * data_w + 1;
  endfunction

  // LSU entry: {rob_id, result}
  function automatic int unsigned lsu_entry_w(input int unsigned rob_id_w, input int unsigned data_w);
    return rob_id_w + data_w;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; full is derived from the occupancy count only.
module cdb_src_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  // Storage write; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_in) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; flush wins over push/pop
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU and LSU writeback onto one registered CDB.
// Optional macro CDB_BYPASS_EN: an incoming result whose FIFO is empty may win
// arbitration in the same cycle and skip the FIFO.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int unsigned ROB_ID_W   = CDB_ROB_ID_W,
  parameter int unsigned DATA_W     = CDB_DATA_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rollback_in,
  input  logic                alu_valid_in,
  input  logic [ROB_ID_W-1:0] alu_rob_id_in,
  input  logic [DATA_W-1:0]   alu_result_in,
  input  logic                alu_jump_flag_in,
  input  logic [DATA_W-1:0]   alu_target_pc_in,
  output logic                alu_full_out,
  input  logic                lsu_valid_in,
  input  logic [ROB_ID_W-1:0] lsu_rob_id_in,
  input  logic [DATA_W-1:0]   lsu_result_in,
  output logic                lsu_full_out,
  output logic                cdb_valid_out,
  output logic                cdb_src_out,
  output logic [ROB_ID_W-1:0] cdb_rob_id_out,
  output logic [DATA_W-1:0]   cdb_result_out,
  output logic                cdb_jump_flag_out,
  output logic [DATA_W-1:0]   cdb_target_pc_out
);

  localparam int unsigned ALU_W = alu_entry_w(ROB_ID_W, DATA_W);
  localparam int unsigned LSU_W = lsu_entry_w(ROB_ID_W, DATA_W);

  logic [ALU_W-1:0] w_alu_in, w_alu_dout, w_alu_head;
  logic [LSU_W-1:0] w_lsu_in, w_lsu_dout, w_lsu_head;
  logic w_alu_empty, w_alu_full, w_lsu_empty, w_lsu_full;
  logic w_alu_tagged, w_lsu_tagged, w_alu_byp, w_lsu_byp;
  logic w_alu_req, w_lsu_req, w_gnt_alu, w_gnt_lsu;
  logic w_fire, w_flush;
  logic w_alu_push, w_lsu_push, w_alu_pop, w_lsu_pop;

  cdb_src_e            r_rr_last;
  logic                r_cdb_valid;
  cdb_src_e            r_cdb_src;
  logic [ROB_ID_W-1:0] r_cdb_rob_id;
  logic [DATA_W-1:0]   r_cdb_result;
  logic                r_cdb_jump;
  logic [DATA_W-1:0]   r_cdb_target;

  assign w_alu_in     = {alu_rob_id_in, alu_result_in, alu_jump_flag_in, alu_target_pc_in};
  assign w_lsu_in     = {lsu_rob_id_in, lsu_result_in};
  assign w_alu_tagged = alu_valid_in & (alu_rob_id_in != '0);
  assign w_lsu_tagged = lsu_valid_in & (lsu_rob_id_in != '0);
  assign w_fire       = rdy_in & ~rollback_in;
  assign w_flush      = rdy_in & rollback_in;

`ifdef CDB_BYPASS_EN
  assign w_alu_byp = w_alu_empty & w_alu_tagged;
  assign w_lsu_byp = w_lsu_empty & w_lsu_tagged;
`else
  assign w_alu_byp = 1'b0;
  assign w_lsu_byp = 1'b0;
`endif

  assign w_alu_req = ~w_alu_empty | w_alu_byp;
  assign w_lsu_req = ~w_lsu_empty | w_lsu_byp;
  assign w_gnt_alu = w_alu_req & (~w_lsu_req | (r_rr_last == CDB_SRC_LSU));
  assign w_gnt_lsu = w_lsu_req & ~w_gnt_alu;

  // A granted empty FIFO can only mean the bypass path carried the result
  assign w_alu_head = w_alu_empty ? w_alu_in : w_alu_dout;
  assign w_lsu_head = w_lsu_empty ? w_lsu_in : w_lsu_dout;

  assign w_alu_push = w_fire & w_alu_tagged & ~w_alu_full & ~(w_alu_byp & w_gnt_alu);
  assign w_lsu_push = w_fire & w_lsu_tagged & ~w_lsu_full & ~(w_lsu_byp & w_gnt_lsu);
  assign w_alu_pop  = w_fire & w_gnt_alu & ~w_alu_empty;
  assign w_lsu_pop  = w_fire & w_gnt_lsu & ~w_lsu_empty;

  cdb_src_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (w_alu_push),
    .pop    (w_alu_pop),
    .flush  (w_flush),
    .din    (w_alu_in),
    .dout   (w_alu_dout),
    .empty  (w_alu_empty),
    .full   (w_alu_full)
  );

  cdb_src_fifo #(.WIDTH(LSU_W), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (w_lsu_push),
    .pop    (w_lsu_pop),
    .flush  (w_flush),
    .din    (w_lsu_in),
    .dout   (w_lsu_dout),
    .empty  (w_lsu_empty),
    .full   (w_lsu_full)
  );

  // CDB output registers and round-robin pointer; payload holds when idle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rr_last    <= CDB_SRC_LSU;
      r_cdb_valid  <= 1'b0;
      r_cdb_src    <= CDB_SRC_ALU;
      r_cdb_rob_id <= '0;
      r_cdb_result <= '0;
      r_cdb_jump   <= 1'b0;
      r_cdb_target <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        r_cdb_valid <= 1'b0;
        r_rr_last   <= CDB_SRC_LSU;
      end else if (w_gnt_alu) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_src    <= CDB_SRC_ALU;
        r_rr_last    <= CDB_SRC_ALU;
        r_cdb_rob_id <= w_alu_head[ALU_W-1 -: ROB_ID_W];
        r_cdb_result <= w_alu_head[2*DATA_W -: DATA_W];
        r_cdb_jump   <= w_alu_head[DATA_W];
        r_cdb_target <= w_alu_head[DATA_W-1:0];
      end else if (w_gnt_lsu) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_src    <= CDB_SRC_LSU;
        r_rr_last    <= CDB_SRC_LSU;
        r_cdb_rob_id <= w_lsu_head[LSU_W-1 -: ROB_ID_W];
        r_cdb_result <= w_lsu_head[DATA_W-1:0];
        r_cdb_jump   <= 1'b0;
        r_cdb_target <= '0;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign alu_full_out      = w_alu_full;
  assign lsu_full_out      = w_lsu_full;
  assign cdb_valid_out     = r_cdb_valid;
  assign cdb_src_out       = r_cdb_src;
  assign cdb_rob_id_out    = r_cdb_rob_id;
  assign cdb_result_out    = r_cdb_result;
  assign cdb_jump_flag_out = r_cdb_jump;
  assign cdb_target_pc_out = r_cdb_target;

  // A source must hold its result while its FIFO is full
  a_alu_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rdy_in && !rollback_in && alu_valid_in) |-> !w_alu_full);
  a_lsu_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rdy_in && !rollback_in && lsu_valid_in) |-> !w_lsu_full);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, FIFO path only).
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_id = '0;
  logic [31:0] alu_res = '0;
  logic        alu_jmp = 1'b0;
  logic [31:0] alu_tgt = '0;
  logic        alu_full;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_id = '0;
  logic [31:0] lsu_res = '0;
  logic        lsu_full;
  logic        cdb_valid;
  logic        cdb_src;
  logic [4:0]  cdb_id;
  logic [31:0] cdb_res;
  logic        cdb_jmp;
  logic [31:0] cdb_tgt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(4), .ROB_ID_W(5), .DATA_W(32)) dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .rdy_in            (rdy),
    .rollback_in       (rollback),
    .alu_valid_in      (alu_valid),
    .alu_rob_id_in     (alu_id),
    .alu_result_in     (alu_res),
    .alu_jump_flag_in  (alu_jmp),
    .alu_target_pc_in  (alu_tgt),
    .alu_full_out      (alu_full),
    .lsu_valid_in      (lsu_valid),
    .lsu_rob_id_in     (lsu_id),
    .lsu_result_in     (lsu_res),
    .lsu_full_out      (lsu_full),
    .cdb_valid_out     (cdb_valid),
    .cdb_src_out       (cdb_src),
    .cdb_rob_id_out    (cdb_id),
    .cdb_result_out    (cdb_res),
    .cdb_jump_flag_out (cdb_jmp),
    .cdb_target_pc_out (cdb_tgt)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_id = '0; alu_res = '0; alu_jmp = 1'b0; alu_tgt = '0;
    lsu_valid = 1'b0; lsu_id = '0; lsu_res = '0;
  endtask

  task automatic drv_alu(input logic [4:0] id, input logic [31:0] res, input logic j, input logic [31:0] tgt);
    alu_valid = 1'b1; alu_id = id; alu_res = res; alu_jmp = j; alu_tgt = tgt;
  endtask

  task automatic drv_lsu(input logic [4:0] id, input logic [31:0] res);
    lsu_valid = 1'b1; lsu_id = id; lsu_res = res;
  endtask

  task automatic do_reset();
    idle();
    rollback = 1'b0;
    rdy = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id, cdb_res, cdb_jmp, cdb_tgt, alu_full, lsu_full} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b src=%0b id=%0d res=%h fulls=%0b%0b want all zero",
               cdb_valid, cdb_src, cdb_id, cdb_res, alu_full, lsu_full);
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    drv_alu(5'd3, 32'h10, 1'b1, 32'h100);
    step();
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_first_edge: got valid=%0b want 0", cdb_valid);
    end
    idle();
    step();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id, cdb_res, cdb_jmp, cdb_tgt} !== {1'b1, 1'b0, 5'd3, 32'h10, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL lat_alu: got v=%0b src=%0b id=%0d res=%h j=%0b tgt=%h want 1 0 3 10 1 100",
               cdb_valid, cdb_src, cdb_id, cdb_res, cdb_jmp, cdb_tgt);
    end
    drv_lsu(5'd5, 32'h55);
    step();
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_lsu_first_edge: got valid=%0b want 0", cdb_valid);
    end
    idle();
    step();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id, cdb_res, cdb_jmp, cdb_tgt} !== {1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL lat_lsu: got v=%0b src=%0b id=%0d res=%h j=%0b tgt=%h want 1 1 5 55 0 0",
               cdb_valid, cdb_src, cdb_id, cdb_res, cdb_jmp, cdb_tgt);
    end
    step();
    n_checks++;
    if ({cdb_valid, cdb_id, cdb_res} !== {1'b0, 5'd5, 32'h55}) begin
      n_fail++;
      $display("FAIL idle_hold: got v=%0b id=%0d res=%h want 0 5 55", cdb_valid, cdb_id, cdb_res);
    end
  endtask

  task automatic test_alternate();
    int ev [8]  = '{0, 1, 1, 1, 1, 1, 1, 0};
    int es [8]  = '{0, 0, 1, 0, 1, 0, 1, 0};
    int eid [8] = '{0, 1, 11, 2, 12, 3, 13, 0};
    logic [31:0] eres;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 3) begin
        drv_alu(5'(i + 1), 32'h100 + 32'(i + 1), 1'b0, 32'h0);
        drv_lsu(5'(i + 11), 32'h200 + 32'(i + 11));
      end
      step();
      eres = (es[i] == 0) ? 32'h100 + 32'(eid[i]) : 32'h200 + 32'(eid[i]);
      n_checks++;
      if (ev[i] == 0) begin
        if (cdb_valid !== 1'b0) begin
          n_fail++; $display("FAIL alt_edge%0d: got valid=%0b want 0", i + 1, cdb_valid);
        end
      end else if ({cdb_valid, cdb_src, cdb_id, cdb_res} !== {1'b1, 1'(es[i]), 5'(eid[i]), eres}) begin
        n_fail++;
        $display("FAIL alt_edge%0d: got v=%0b src=%0b id=%0d res=%h want 1 %0d %0d %h",
                 i + 1, cdb_valid, cdb_src, cdb_id, cdb_res, es[i], eid[i], eres);
      end
    end
  endtask

  task automatic test_saturate();
    int ev [14]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int es [14]  = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int eid [14] = '{0, 1, 11, 2, 12, 3, 13, 4, 14, 5, 15, 6, 16, 0};
    int efl [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] eres;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      idle();
      if (i < 6) begin
        drv_alu(5'(i + 1), 32'h100 + 32'(i + 1), 1'b0, 32'h0);
        drv_lsu(5'(i + 11), 32'h200 + 32'(i + 11));
      end
      step();
      eres = (es[i] == 0) ? 32'h100 + 32'(eid[i]) : 32'h200 + 32'(eid[i]);
      n_checks++;
      if ({lsu_full, alu_full} !== {1'(efl[i]), 1'b0}) begin
        n_fail++;
        $display("FAIL sat_full_edge%0d: got lsu_full=%0b alu_full=%0b want %0d 0", i + 1, lsu_full, alu_full, efl[i]);
      end
      n_checks++;
      if (ev[i] == 0) begin
        if (cdb_valid !== 1'b0) begin
          n_fail++; $display("FAIL sat_edge%0d: got valid=%0b want 0", i + 1, cdb_valid);
        end
      end else if ({cdb_valid, cdb_src, cdb_id, cdb_res} !== {1'b1, 1'(es[i]), 5'(eid[i]), eres}) begin
        n_fail++;
        $display("FAIL sat_edge%0d: got v=%0b src=%0b id=%0d res=%h want 1 %0d %0d %h",
                 i + 1, cdb_valid, cdb_src, cdb_id, cdb_res, es[i], eid[i], eres);
      end
    end
  endtask

  task automatic test_rollback();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv_alu(5'(i + 1), 32'h100 + 32'(i + 1), 1'b0, 32'h0);
      drv_lsu(5'(i + 11), 32'h200 + 32'(i + 11));
      step();
    end
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id} !== {1'b1, 1'b1, 5'd11}) begin
      n_fail++; $display("FAIL rb_pre: got v=%0b src=%0b id=%0d want 1 1 11", cdb_valid, cdb_src, cdb_id);
    end
    idle();
    drv_alu(5'd9, 32'h999, 1'b0, 32'h0);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    idle();
    n_checks++;
    if ({cdb_valid, cdb_id, alu_full, lsu_full} !== {1'b0, 5'd11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rb_edge: got v=%0b id=%0d fulls=%0b%0b want 0 11 00", cdb_valid, cdb_id, alu_full, lsu_full);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL rb_stale%0d: got valid=%0b id=%0d want valid 0", i, cdb_valid, cdb_id);
      end
    end
    drv_alu(5'd7, 32'h107, 1'b0, 32'h0);
    step();
    idle();
    step();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id, cdb_res} !== {1'b1, 1'b0, 5'd7, 32'h107}) begin
      n_fail++;
      $display("FAIL rb_after: got v=%0b src=%0b id=%0d res=%h want 1 0 7 107", cdb_valid, cdb_src, cdb_id, cdb_res);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drv_alu(5'(i + 1), 32'h100 + 32'(i + 1), 1'b0, 32'h0);
      drv_lsu(5'(i + 11), 32'h200 + 32'(i + 11));
      step();
    end
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id, cdb_res, cdb_jmp, cdb_tgt, alu_full, lsu_full} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%0b src=%0b id=%0d res=%h want all zero", cdb_valid, cdb_src, cdb_id, cdb_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drv_alu(5'd4, 32'h104, 1'b0, 32'h0);
    drv_lsu(5'd14, 32'h214);
    step();
    idle();
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flushed: got valid=%0b id=%0d want valid 0", cdb_valid, cdb_id);
    end
    step();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id} !== {1'b1, 1'b0, 5'd4}) begin
      n_fail++; $display("FAIL rst_mid_first: got v=%0b src=%0b id=%0d want 1 0 4", cdb_valid, cdb_src, cdb_id);
    end
    step();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id} !== {1'b1, 1'b1, 5'd14}) begin
      n_fail++; $display("FAIL rst_mid_second: got v=%0b src=%0b id=%0d want 1 1 14", cdb_valid, cdb_src, cdb_id);
    end
  endtask

  task automatic test_tag0();
    do_reset();
    drv_alu(5'd0, 32'h77, 1'b1, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) idle();
      n_checks++;
      if (cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL tag0_%0d: got valid=%0b id=%0d want valid 0", i, cdb_valid, cdb_id);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    drv_alu(5'd1, 32'h101, 1'b0, 32'h0);
    drv_lsu(5'd11, 32'h211);
    step();
    idle();
    step();
    rdy = 1'b0;
    rollback = 1'b1;
    drv_alu(5'd2, 32'h102, 1'b0, 32'h0);
    drv_lsu(5'd12, 32'h212);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({cdb_valid, cdb_src, cdb_id, cdb_res, alu_full, lsu_full} !== {1'b1, 1'b0, 5'd1, 32'h101, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL freeze%0d: got v=%0b src=%0b id=%0d res=%h want 1 0 1 101", i, cdb_valid, cdb_src, cdb_id, cdb_res);
      end
    end
    rdy = 1'b1;
    rollback = 1'b0;
    idle();
    step();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_id, cdb_res} !== {1'b1, 1'b1, 5'd11, 32'h211}) begin
      n_fail++;
      $display("FAIL freeze_resume: got v=%0b src=%0b id=%0d res=%h want 1 1 11 211", cdb_valid, cdb_src, cdb_id, cdb_res);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL freeze_no_enq: got valid=%0b id=%0d want valid 0", cdb_valid, cdb_id);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_alternate();
    test_saturate();
    test_rollback();
    test_reset_mid();
    test_tag0();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
